conn_table_arb: RTL and testbench
=================================

CONN_TABLE_ARB -- requirements
Module: conn_table_arb

Interface
REQ-001 SHALL have parameter KEY_W, default 104, meaning 5-tuple key width {src_ip, dst_ip, src_port, dst_port, protocol}.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning connection table index width.
REQ-003 SHALL have parameter MAX_PROBE, default 16, meaning maximum slots examined per request, range 1..2^ADDR_W.
REQ-004 SHALL have port clk  in  1  single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports reqN_valid  in  1  request valid from requester N (N=0 outbound path, N=1 inbound path).
REQ-007 SHALL have ports reqN_ready  out  1  request accepted on this cycle when reqN_valid is also high.
REQ-008 SHALL have ports reqN_key  in  KEY_W  lookup/insert key.
REQ-009 SHALL have ports reqN_hash  in  ADDR_W  first slot to probe.
REQ-010 SHALL have ports rspN_valid  out  1  one-cycle response pulse.
REQ-011 SHALL have ports rspN_id  out  ADDR_W  slot index holding the key.
REQ-012 SHALL have ports rspN_new  out  1  slot was empty and the key was inserted.
REQ-013 SHALL have ports rspN_fail  out  1  no slot found, or key is all-zero.
REQ-014 SHALL have port mem_addr  out  ADDR_W  table address.
REQ-015 SHALL have port mem_rd_en  out  1  read strobe; data returns on mem_rd_data exactly 1 cycle later.
REQ-016 SHALL have port mem_rd_data  in  KEY_W  slot contents; all-zero means empty.
REQ-017 SHALL have port mem_wr_en  out  1  write strobe.
REQ-018 SHALL have port mem_wr_data  out  KEY_W  data written at mem_addr.

Function
REQ-019 SHALL implement FSM states IDLE, RD, CMP, RESP, with exactly one request in service at a time.
REQ-020 In IDLE, SHALL assert reqN_ready combinationally only for the granted requester; all ready outputs SHALL be low outside IDLE.
REQ-021 Grant SHALL be round-robin: if only one request is valid, grant it; if both are valid, grant the requester not served last.
REQ-022 On handshake, SHALL latch key, hash, and requester id, clear probe_cnt, and go to RD; if the key is all-zero, SHALL instead go straight to RESP with fail=1 and perform no memory access.
REQ-023 RD: SHALL drive mem_rd_en=1 with mem_addr=current slot, then go to CMP.
REQ-024 CMP, mem_rd_data == key: SHALL set id=slot, new=0, fail=0, and go to RESP.
REQ-025 CMP, mem_rd_data == 0: SHALL drive mem_wr_en=1, mem_addr=slot, mem_wr_data=key for one cycle, set id=slot, new=1, and go to RESP.
REQ-026 CMP, otherwise: if probe_cnt == MAX_PROBE-1, SHALL set fail=1, id=0, and go to RESP; else SHALL increment probe_cnt, set slot=slot+1 modulo 2^ADDR_W (wrap from 0xFFFF to 0x0000), and go to RD.
REQ-027 A key match SHALL take priority over empty (the two are mutually exclusive because the key is non-zero).
REQ-028 RESP: SHALL pulse rspN_valid=1 for one cycle for the served requester only, with rspN_id/new/fail held valid in that cycle, then return to IDLE.
REQ-029 rspN_id/new/fail SHALL hold their last value between pulses.
REQ-030 Latency from accept edge to response SHALL be 3 cycles for a first-slot result, plus 2 cycles per additional probe, and 1 cycle for a zero key.
REQ-031 mem_rd_en and mem_wr_en SHALL never be high in the same cycle, and SHALL be low in IDLE and RESP.
REQ-032 The arbiter SHALL ignore requester valid changes while busy; a requester SHALL hold key/hash stable until ready is seen.

Reset
REQ-033 rst high at a clock edge SHALL force IDLE, abandon any in-flight request with no response pulse and no write, and set last_served=1 so requester 0 wins the first tie.
REQ-034 During and after reset, all outputs SHALL be 0: ready, rsp_valid, rsp_id, rsp_new, rsp_fail, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data.
REQ-035 Reset SHALL NOT clear the table memory.

Verification
REQ-036 Empty table, req0 key=K1, hash=0x0010 -> one write to 0x0010, rsp0_valid 3 cycles after accept with id=0x0010, new=1, fail=0.
REQ-037 Repeat K1 from req1 -> rsp1 id=0x0010, new=0, no write.
REQ-038 Slots 0xFFFF and 0x0000 occupied by other keys, key K2, hash=0xFFFF -> probes 0xFFFF, 0x0000, then 0x0001; K2 written at 0x0001; response 7 cycles after accept with new=1.
REQ-039 MAX_PROBE=4 with 4 consecutive occupied slots -> fail=1 after exactly 4 reads, no write.
REQ-040 req0 and req1 held valid continuously -> grants alternate 0,1,0,1; zero key -> fail pulse 1 cycle after accept with no memory access.
REQ-041 rst asserted in CMP with empty data -> no mem_wr_en, no rsp_valid; the next request is served normally.

Source files
------------

// File: rtl/conn_table_arb_if.sv
// rtl/conn_table_arb_if.sv - requester, response and table-memory signals of the connection table arbiter
interface conn_table_arb_if #(
    parameter int KEY_W  = 104,
    parameter int ADDR_W = 16
);
    logic              req0_valid;
    logic              req0_ready;
    logic [KEY_W-1:0]  req0_key;
    logic [ADDR_W-1:0] req0_hash;
    logic              req1_valid;
    logic              req1_ready;
    logic [KEY_W-1:0]  req1_key;
    logic [ADDR_W-1:0] req1_hash;

    logic              rsp0_valid;
    logic [ADDR_W-1:0] rsp0_id;
    logic              rsp0_new;
    logic              rsp0_fail;
    logic              rsp1_valid;
    logic [ADDR_W-1:0] rsp1_id;
    logic              rsp1_new;
    logic              rsp1_fail;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [KEY_W-1:0]  mem_rd_data;
    logic              mem_wr_en;
    logic [KEY_W-1:0]  mem_wr_data;

    modport slave (
        input  req0_valid, req0_key, req0_hash, req1_valid, req1_key, req1_hash, mem_rd_data,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_id, rsp0_new, rsp0_fail,
        output rsp1_valid, rsp1_id, rsp1_new, rsp1_fail,
        output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
    );

    modport master (
        output req0_valid, req0_key, req0_hash, req1_valid, req1_key, req1_hash, mem_rd_data,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_id, rsp0_new, rsp0_fail,
        input  rsp1_valid, rsp1_id, rsp1_new, rsp1_fail,
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/conn_table_arb.sv
// rtl/conn_table_arb.sv - two-requester round-robin lookup/insert engine for a linear-probed connection table
module conn_table_arb #(
    parameter int KEY_W     = 104,
    parameter int ADDR_W    = 16,
    parameter int MAX_PROBE = 16
) (
    input  logic             clk,
    input  logic             rst,
    conn_table_arb_if.slave  bus
);
    localparam int PW = $clog2(MAX_PROBE) + 1;

    typedef enum logic [1:0] {IDLE, RD, CMP, RESP} state_t;

    state_t            state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [ADDR_W-1:0] slot_q, slot_d;
    logic [PW-1:0]     probe_cnt_q, probe_cnt_d;
    logic              sel_q, sel_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] id0_q, id0_d, id1_q, id1_d;
    logic              new0_q, new0_d, new1_q, new1_d;
    logic              fail0_q, fail0_d, fail1_q, fail1_d;

    logic              grant0, grant1, wr_hit, rd_en, wr_en;
    logic              res_load, res_new, res_fail;
    logic [ADDR_W-1:0] res_id, acc_hash;
    logic [KEY_W-1:0]  acc_key;

    always_comb begin
        grant0   = (state_q == IDLE) && bus.req0_valid && (!bus.req1_valid || last_q);
        grant1   = (state_q == IDLE) && bus.req1_valid && (!bus.req0_valid || !last_q);
        acc_key  = grant1 ? bus.req1_key  : bus.req0_key;
        acc_hash = grant1 ? bus.req1_hash : bus.req0_hash;

        state_d     = state_q;
        key_d       = key_q;
        slot_d      = slot_q;
        probe_cnt_d = probe_cnt_q;
        sel_d       = sel_q;
        last_d      = last_q;
        res_load    = 1'b0;
        res_id      = '0;
        res_new     = 1'b0;
        res_fail    = 1'b0;
        wr_hit      = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    key_d       = acc_key;
                    slot_d      = acc_hash;
                    probe_cnt_d = '0;
                    sel_d       = grant1;
                    last_d      = grant1;
                    // An all-zero key would be indistinguishable from an empty slot.
                    if (acc_key == '0) begin
                        state_d  = RESP;
                        res_load = 1'b1;
                        res_fail = 1'b1;
                    end else begin
                        state_d  = RD;
                    end
                end
            end
            RD: state_d = CMP;
            CMP: begin
                if (bus.mem_rd_data == key_q) begin
                    state_d  = RESP;
                    res_load = 1'b1;
                    res_id   = slot_q;
                end else if (bus.mem_rd_data == '0) begin
                    state_d  = RESP;
                    wr_hit   = 1'b1;
                    res_load = 1'b1;
                    res_id   = slot_q;
                    res_new  = 1'b1;
                end else if (probe_cnt_q == PW'(MAX_PROBE - 1)) begin
                    state_d  = RESP;
                    res_load = 1'b1;
                    res_fail = 1'b1;
                end else begin
                    state_d     = RD;
                    probe_cnt_d = probe_cnt_q + 1'b1;
                    slot_d      = slot_q + 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        id0_d   = id0_q;
        new0_d  = new0_q;
        fail0_d = fail0_q;
        id1_d   = id1_q;
        new1_d  = new1_q;
        fail1_d = fail1_q;
        if (res_load && sel_d) begin
            id1_d   = res_id;
            new1_d  = res_new;
            fail1_d = res_fail;
        end else if (res_load) begin
            id0_d   = res_id;
            new0_d  = res_new;
            fail0_d = res_fail;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            key_q       <= '0;
            slot_q      <= '0;
            probe_cnt_q <= '0;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            id0_q       <= '0;
            new0_q      <= 1'b0;
            fail0_q     <= 1'b0;
            id1_q       <= '0;
            new1_q      <= 1'b0;
            fail1_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            slot_q      <= slot_d;
            probe_cnt_q <= probe_cnt_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            id0_q       <= id0_d;
            new0_q      <= new0_d;
            fail0_q     <= fail0_d;
            id1_q       <= id1_d;
            new1_q      <= new1_d;
            fail1_q     <= fail1_d;
        end
    end

    // Gating with rst keeps a write from landing in the same cycle reset abandons the request.
    assign rd_en           = (state_q == RD) && !rst;
    assign wr_en           = wr_hit && !rst;
    assign bus.mem_rd_en   = rd_en;
    assign bus.mem_wr_en   = wr_en;
    assign bus.mem_addr    = (rd_en || wr_en) ? slot_q : '0;
    assign bus.mem_wr_data = wr_en ? key_q : '0;

    assign bus.req0_ready  = grant0 && !rst;
    assign bus.req1_ready  = grant1 && !rst;
    assign bus.rsp0_valid  = (state_q == RESP) && !sel_q && !rst;
    assign bus.rsp1_valid  = (state_q == RESP) &&  sel_q && !rst;
    assign bus.rsp0_id     = rst ? '0 : id0_q;
    assign bus.rsp0_new    = new0_q  && !rst;
    assign bus.rsp0_fail   = fail0_q && !rst;
    assign bus.rsp1_id     = rst ? '0 : id1_q;
    assign bus.rsp1_new    = new1_q  && !rst;
    assign bus.rsp1_fail   = fail1_q && !rst;
endmodule

// File: tb/tb_conn_table_arb.sv
// tb/tb_conn_table_arb.sv - randomized bench for conn_table_arb against a probing table model
module tb_conn_table_arb;
    localparam int KEY_W = 104, ADDR_W = 16, MAX_PROBE = 4;
    localparam logic [KEY_W-1:0] K1 = 104'hC0A80001_0A000001_1F90_0050_06;
    localparam logic [KEY_W-1:0] K2 = 104'hC0A80002_0A000001_2710_01BB_06;
    localparam logic [KEY_W-1:0] K3 = 104'hC0A80003_0A000002_3039_0035_11;
    localparam logic [KEY_W-1:0] K4 = 104'hC0A80004_0A000003_4E20_0016_06;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conn_table_arb_if #(.KEY_W(KEY_W), .ADDR_W(ADDR_W)) bus ();
    conn_table_arb #(.KEY_W(KEY_W), .ADDR_W(ADDR_W), .MAX_PROBE(MAX_PROBE)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    bit [KEY_W-1:0] mem     [65536];
    bit [KEY_W-1:0] ref_tab [65536];
    bit             last_model;
    int             n_checks = 0;
    int             n_fail   = 0;

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [KEY_W-1:0] fkey(input int i);
        return {32'hAC100000 + 32'(i), 32'h08080808, 16'(i), 16'd443, 8'd17};
    endfunction

    // Linear probe over the reference table: hit, claim the first empty slot, or give up.
    task automatic model(input logic [KEY_W-1:0] key, input logic [15:0] hash,
                         output logic [15:0] e_id, output bit e_new, output bit e_fail,
                         output int e_lat, output int e_rd, output int e_wr);
        logic [15:0] s;
        e_id = '0; e_new = 1'b0; e_fail = 1'b1; e_lat = 1; e_rd = 0; e_wr = 0;
        if (key == '0) return;
        for (int i = 0; i < MAX_PROBE; i++) begin
            s     = hash + 16'(i);
            e_rd  = i + 1;
            e_lat = 3 + 2 * i;
            if (ref_tab[s] == key) begin
                e_id = s; e_fail = 1'b0; return;
            end
            if (ref_tab[s] == '0) begin
                e_id = s; e_fail = 1'b0; e_new = 1'b1; e_wr = 1; ref_tab[s] = key; return;
            end
        end
    endtask

    task automatic drive(input int n, input bit v, input logic [KEY_W-1:0] key, input logic [15:0] hash);
        if (n == 0) begin bus.req0_valid = v; bus.req0_key = key; bus.req0_hash = hash; end
        else        begin bus.req1_valid = v; bus.req1_key = key; bus.req1_hash = hash; end
    endtask

    task automatic do_req(input int n, input logic [KEY_W-1:0] key, input logic [15:0] hash, input string tag);
        logic [15:0] e_id, r_id, w_addr;
        logic [KEY_W-1:0] w_data;
        logic r_new, r_fail;
        bit e_new, e_fail, got;
        int e_lat, e_rd, e_wr, rd_cnt, wr_cnt, lat, bad;
        model(key, hash, e_id, e_new, e_fail, e_lat, e_rd, e_wr);
        got = 0; rd_cnt = 0; wr_cnt = 0; lat = 0; bad = 0;
        r_id = '0; r_new = 1'b0; r_fail = 1'b0; w_addr = '0; w_data = '0;
        @(negedge clk);
        drive(n, 1'b1, key, hash);
        for (int t = 0; t < 10; t++) begin
            #1;
            if ((n == 0) ? bus.req0_ready : bus.req1_ready) begin got = 1; break; end
            @(negedge clk);
        end
        check({tag, " accept"}, 128'(got), 128'(1));
        if (!got) begin drive(n, 1'b0, '0, '0); return; end
        @(posedge clk);
        #1 drive(n, 1'b0, '0, '0);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.mem_rd_en) rd_cnt++;
            if (bus.mem_wr_en) begin wr_cnt++; w_addr = bus.mem_addr; w_data = bus.mem_wr_data; end
            if (bus.mem_rd_en && bus.mem_wr_en) bad++;
            if ((n == 0) ? bus.rsp1_valid : bus.rsp0_valid) bad++;
            if ((n == 0) ? bus.rsp0_valid : bus.rsp1_valid) begin
                lat    = c;
                r_id   = (n == 0) ? bus.rsp0_id   : bus.rsp1_id;
                r_new  = (n == 0) ? bus.rsp0_new  : bus.rsp1_new;
                r_fail = (n == 0) ? bus.rsp0_fail : bus.rsp1_fail;
                break;
            end
        end
        check({tag, " latency"}, 128'(lat), 128'(e_lat));
        check({tag, " id"},      128'(r_id), 128'(e_id));
        check({tag, " new"},     128'(r_new), 128'(e_new));
        check({tag, " fail"},    128'(r_fail), 128'(e_fail));
        check({tag, " reads"},   128'(rd_cnt), 128'(e_rd));
        check({tag, " writes"},  128'(wr_cnt), 128'(e_wr));
        check({tag, " hygiene"}, 128'(bad), 128'(0));
        if (e_wr != 0) begin
            check({tag, " wr addr"}, 128'(w_addr), 128'(e_id));
            check({tag, " wr data"}, 128'(w_data), 128'(key));
        end
        last_model = n[0];
    endtask

    logic [KEY_W-1:0] pool [6];
    logic [KEY_W-1:0] rk;
    logic [15:0]      rh;
    int               rn, pulses, fails, acc, both_rdy, wr_seen, bad_img, first;
    int               g[$];

    initial begin
        drive(0, 1'b1, K1, 16'h0010);
        drive(1, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        check("rst ready0",     128'(bus.req0_ready), 128'(0));
        check("rst rsp valid",  128'({bus.rsp0_valid, bus.rsp1_valid}), 128'(0));
        check("rst rsp fields", 128'({bus.rsp0_id, bus.rsp0_new, bus.rsp0_fail, bus.rsp1_id, bus.rsp1_new, bus.rsp1_fail}), 128'(0));
        check("rst mem ctl",    128'({bus.mem_addr, bus.mem_rd_en, bus.mem_wr_en}), 128'(0));
        check("rst mem wdata",  128'(bus.mem_wr_data), 128'(0));
        drive(0, 1'b0, '0, '0);
        rst = 1'b0;
        last_model = 1'b1;
        @(negedge clk);
        check("idle mem ctl", 128'({bus.mem_rd_en, bus.mem_wr_en, bus.req0_ready, bus.req1_ready}), 128'(0));

        do_req(0, K1, 16'h0010, "insert K1");
        check("K1 stored", 128'(mem[16'h0010]), 128'(K1));
        do_req(1, K1, 16'h0010, "hit K1");
        do_req(0, fkey(1), 16'hFFFF, "fill FFFF");
        do_req(1, fkey(2), 16'h0000, "fill 0000");
        do_req(0, K2, 16'hFFFF, "wrap K2");
        check("K2 stored", 128'(mem[16'h0001]), 128'(K2));
        for (int i = 0; i < 4; i++) do_req(i % 2, fkey(10 + i), 16'h0100 + 16'(i), "fill run");
        do_req(0, K3, 16'h0100, "exhaust");
        do_req(1, '0, 16'h1234, "zero key");

        // Both requesters held valid with zero keys: one grant every other cycle.
        @(negedge clk);
        drive(0, 1'b1, '0, 16'h0042);
        drive(1, 1'b1, '0, 16'h0043);
        pulses = 0; fails = 0; acc = 0; both_rdy = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus.req0_ready && bus.req1_ready) both_rdy++;
            if (bus.req0_ready) g.push_back(0);
            if (bus.req1_ready) g.push_back(1);
            if (bus.rsp0_valid || bus.rsp1_valid) pulses++;
            if ((bus.rsp0_valid && bus.rsp0_fail) || (bus.rsp1_valid && bus.rsp1_fail)) fails++;
            if (bus.mem_rd_en || bus.mem_wr_en) acc++;
            @(negedge clk);
        end
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        first = last_model ? 0 : 1;
        check("rr grants", 128'(g.size()), 128'(4));
        for (int k = 0; k < g.size(); k++) check("rr order", 128'(g[k]), 128'((first + k) % 2));
        check("rr both ready", 128'(both_rdy), 128'(0));
        check("rr pulses", 128'(pulses), 128'(4));
        check("rr fails", 128'(fails), 128'(4));
        check("rr mem access", 128'(acc), 128'(0));
        if (g.size() > 0) last_model = g[g.size() - 1][0];
        repeat (2) @(negedge clk);

        // Reset lands while the engine is comparing against an empty slot.
        drive(0, 1'b1, K4, 16'h0200);
        #1 check("rstcmp accept", 128'(bus.req0_ready), 128'(1));
        @(posedge clk);
        #1 drive(0, 1'b0, '0, '0);
        @(negedge clk);
        check("rstcmp read", 128'(bus.mem_rd_en), 128'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check("rstcmp wr gated", 128'({bus.mem_wr_en, bus.mem_rd_en, bus.rsp0_valid}), 128'(0));
        pulses = 0; wr_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp0_valid || bus.rsp1_valid) pulses++;
            if (bus.mem_wr_en) wr_seen++;
        end
        rst = 1'b0;
        last_model = 1'b1;
        check("rstcmp pulses", 128'(pulses), 128'(0));
        check("rstcmp writes", 128'(wr_seen), 128'(0));
        check("rstcmp slot empty", 128'(mem[16'h0200]), 128'(0));
        do_req(1, K4, 16'h0200, "after rst");

        for (int i = 0; i < 6; i++) pool[i] = KEY_W'({$urandom, $urandom, $urandom, $urandom}) | 1;
        for (int i = 0; i < 150; i++) begin
            rn = $urandom_range(0, 1);
            rk = ($urandom_range(0, 15) == 0) ? '0 : pool[$urandom_range(0, 5)];
            rh = 16'hFFFC + 16'($urandom_range(0, 7));
            do_req(rn, rk, rh, "rand");
        end

        bad_img = 0;
        for (int a = 0; a < 65536; a++) if (mem[a] != ref_tab[a]) bad_img++;
        check("table image", 128'(bad_img), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
